// File: rtl/instr_encoder.sv
// RV32I subset encoder and sequential instruction-memory loader.
// Packs symbolic fields into 32-bit words and writes them through an acked port.
module instr_encoder #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_op,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic [31:0]           in_imm,
  input  logic                  in_last,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_ack,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            err_code
);

  localparam int unsigned CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

  localparam logic [2:0] OP_LW   = 3'b000;
  localparam logic [2:0] OP_SW   = 3'b001;
  localparam logic [2:0] OP_ADDI = 3'b010;
  localparam logic [2:0] OP_BEQ  = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;
  localparam logic [2:0] OP_AND  = 3'b110;
  localparam logic [2:0] OP_OR   = 3'b111;

  localparam logic [1:0] E_NONE  = 2'b00;
  localparam logic [1:0] E_RANGE = 2'b01;
  localparam logic [1:0] E_ODD   = 2'b10;
  localparam logic [1:0] E_FULL  = 2'b11;

  typedef enum logic [1:0] {IDLE, WRITE, DONE, ERROR} state_t;

  state_t                state_q, state_n;
  logic                  last_q, last_n;
  logic                  we_q, we_n;
  logic [ADDR_WIDTH-1:0] addr_q, addr_n;
  logic [31:0]           wdata_q, wdata_n;
  logic [CW-1:0]         count_q, count_n;
  logic                  done_q, done_n;
  logic                  err_q, err_n;
  logic [1:0]            code_q, code_n;

  logic signed [31:0] imm_s;
  logic               imm12_bad, imm13_bad;
  logic [1:0]         fail_code;
  logic [31:0]        word;
  logic [6:0]         funct7;
  logic [2:0]         funct3;

  assign imm_s     = $signed(in_imm);
  assign imm12_bad = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
  assign imm13_bad = (imm_s < -32'sd4096) || (imm_s > 32'sd4094);

  // Acceptance checks in priority order: capacity, range, branch alignment.
  always_comb begin
    fail_code = E_NONE;
    if (count_q == FULL) begin
      fail_code = E_FULL;
    end else begin
      case (in_op)
        OP_LW, OP_SW, OP_ADDI: if (imm12_bad) fail_code = E_RANGE;
        OP_BEQ: begin
          if (imm13_bad)      fail_code = E_RANGE;
          else if (in_imm[0]) fail_code = E_ODD;
        end
        default: fail_code = E_NONE;
      endcase
    end
  end

  // Instruction word packing.
  always_comb begin
    funct7 = 7'b0000000;
    funct3 = 3'b000;
    case (in_op)
      OP_SUB: funct7 = 7'b0100000;
      OP_AND: funct3 = 3'b111;
      OP_OR:  funct3 = 3'b110;
      default: ;
    endcase
    case (in_op)
      OP_LW:   word = {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'b0000011};
      OP_SW:   word = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'b0100011};
      OP_ADDI: word = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b0010011};
      OP_BEQ:  word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000,
                       in_imm[4:1], in_imm[11], 7'b1100011};
      default: word = {funct7, in_rs2, in_rs1, funct3, in_rd, 7'b0110011};
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_n = state_q;
    last_n  = last_q;
    we_n    = we_q;
    addr_n  = addr_q;
    wdata_n = wdata_q;
    count_n = count_q;
    done_n  = done_q;
    err_n   = err_q;
    code_n  = code_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (fail_code != E_NONE) begin
            state_n = ERROR;
            err_n   = 1'b1;
            code_n  = fail_code;
          end else begin
            state_n = WRITE;
            we_n    = 1'b1;
            addr_n  = ADDR_WIDTH'(BASE_ADDR) + count_q[ADDR_WIDTH-1:0];
            wdata_n = word;
            last_n  = in_last;
          end
        end
      end
      WRITE: begin
        if (mem_ack) begin
          we_n    = 1'b0;
          count_n = count_q + CW'(1);
          if (last_q) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= ADDR_WIDTH'(BASE_ADDR);
      wdata_q <= 32'd0;
      count_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= E_NONE;
    end else begin
      state_q <= state_n;
      last_q  <= last_n;
      we_q    <= we_n;
      addr_q  <= addr_n;
      wdata_q <= wdata_n;
      count_q <= count_n;
      done_q  <= done_n;
      err_q   <= err_n;
      code_q  <= code_n;
    end
  end

  assign in_ready  = (state_q == IDLE) && !reset;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign count     = count_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_code  = code_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: default 8-bit-address instance plus a 2-bit one.
module tb_instr_encoder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = 3'd0;
  logic [4:0]  in_rd = 5'd0, in_rs1 = 5'd0, in_rs2 = 5'd0;
  logic [31:0] in_imm = 32'd0;
  logic        in_last = 1'b0;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [8:0]  count;
  logic        done, err;
  logic [1:0]  err_code;

  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        s_we;
  logic [1:0]  s_addr;
  logic [31:0] s_wdata;
  logic        s_ack = 1'b0;
  logic [2:0]  s_count;
  logic        s_done, s_err;
  logic [1:0]  s_code;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  instr_encoder u_dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .in_last(in_last), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .count(count), .done(done),
    .err(err), .err_code(err_code)
  );

  instr_encoder #(.ADDR_WIDTH(2), .BASE_ADDR(0)) u_small (
    .clock(clock), .reset(reset), .in_valid(s_valid), .in_ready(s_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .in_last(in_last), .mem_we(s_we), .mem_addr(s_addr),
    .mem_wdata(s_wdata), .mem_ack(s_ack), .count(s_count), .done(s_done),
    .err(s_err), .err_code(s_code)
  );

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; in_valid = 1'b0; s_valid = 1'b0; mem_ack = 1'b0; s_ack = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
  endtask

  task automatic set_fields(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [31:0] imm, input logic last);
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_last = last;
  endtask

  // One accepted instruction on the main instance, acked after 'delay' waiting cycles.
  task automatic wr(input string name, input logic [2:0] op, input logic [4:0] rd,
                    input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                    input logic last, input int delay, input logic [7:0] eaddr,
                    input logic [31:0] eword, input logic [8:0] ecount);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL %s ready got=%b exp=1", name, in_ready); end
    set_fields(op, rd, rs1, rs2, imm, last);
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL %s we got=%b exp=1", name, mem_we); end
    total++; if (mem_addr !== eaddr) begin bad++; $display("FAIL %s addr got=%0d exp=%0d", name, mem_addr, eaddr); end
    total++; if (mem_wdata !== eword) begin bad++; $display("FAIL %s word got=%h exp=%h", name, mem_wdata, eword); end
    for (int i = 0; i < delay; i++) begin
      @(negedge clock);
      total++;
      if (mem_we !== 1'b1 || mem_addr !== eaddr || mem_wdata !== eword || count !== ecount - 9'd1) begin
        bad++;
        $display("FAIL %s stall%0d we=%b addr=%0d word=%h cnt=%0d exp we=1 addr=%0d word=%h cnt=%0d",
                 name, i, mem_we, mem_addr, mem_wdata, count, eaddr, eword, ecount - 9'd1);
      end
    end
    mem_ack = 1'b1;
    @(negedge clock);
    mem_ack = 1'b0;
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL %s we_after_ack got=%b exp=0", name, mem_we); end
    total++; if (count !== ecount) begin bad++; $display("FAIL %s count got=%0d exp=%0d", name, count, ecount); end
    total++; if (done !== last) begin bad++; $display("FAIL %s done got=%b exp=%b", name, done, last); end
    total++; if (in_ready !== !last) begin bad++; $display("FAIL %s ready_after got=%b exp=%b", name, in_ready, !last); end
  endtask

  // Offer one instruction that must be rejected with the given code.
  task automatic rej(input string name, input logic [2:0] op, input logic [31:0] imm,
                     input logic [1:0] ecode);
    set_fields(op, 5'd1, 5'd2, 5'd3, imm, 1'b0);
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL %s we got=%b exp=0", name, mem_we); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL %s err got=%b exp=1", name, err); end
    total++; if (err_code !== ecode) begin bad++; $display("FAIL %s code got=%b exp=%b", name, err_code, ecode); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL %s ready got=%b exp=0", name, in_ready); end
  endtask

  task automatic test_reset();
    @(negedge clock);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", in_ready); end
    total++; if (mem_we !== 1'b0 || mem_addr !== 8'd0 || mem_wdata !== 32'd0) begin
      bad++; $display("FAIL rst_mem we=%b addr=%0d word=%h exp 0/0/0", mem_we, mem_addr, mem_wdata); end
    total++; if (count !== 9'd0 || done !== 1'b0 || err !== 1'b0 || err_code !== 2'b00) begin
      bad++; $display("FAIL rst_status cnt=%0d done=%b err=%b code=%b exp 0", count, done, err, err_code); end
    do_reset();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    wr("lw",  3'b000, 5'd5, 5'd10, 5'd0, 32'd48, 1'b0, 0, 8'd0, 32'h03052283, 9'd1);
    wr("sw",  3'b001, 5'd0, 5'd10, 5'd5, 32'd0,  1'b0, 0, 8'd1, 32'h00552023, 9'd2);
  endtask

  task automatic test_last();
    do_reset();
    wr("addi_neg", 3'b010, 5'd5, 5'd6, 5'd0, -32'sd2046, 1'b0, 0, 8'd0, 32'h80230293, 9'd1);
    wr("beq_last", 3'b011, 5'd0, 5'd9, 5'd8, -32'sd2,    1'b1, 0, 8'd1, 32'hFE848FE3, 9'd2);
    set_fields(3'b100, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0);
    in_valid = 1'b1; mem_ack = 1'b1;
    @(negedge clock);
    in_valid = 1'b0; mem_ack = 1'b0;
    total++; if (mem_we !== 1'b0 || count !== 9'd2 || done !== 1'b1 || in_ready !== 1'b0) begin
      bad++; $display("FAIL done_absorb we=%b cnt=%0d done=%b ready=%b exp 0/2/1/0", mem_we, count, done, in_ready); end
  endtask

  task automatic test_ack_stall();
    do_reset();
    wr("add", 3'b100, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 3, 8'd0, 32'h003100B3, 9'd1);
    wr("sub", 3'b101, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 3, 8'd1, 32'h403100B3, 9'd2);
    wr("and", 3'b110, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 0, 8'd2, 32'h003170B3, 9'd3);
    wr("or",  3'b111, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 0, 8'd3, 32'h003160B3, 9'd4);
  endtask

  task automatic test_imm_range();
    do_reset();
    rej("addi_2048", 3'b010, 32'd2048, 2'b01);
    @(negedge clock);
    total++; if (err !== 1'b1 || err_code !== 2'b01) begin
      bad++; $display("FAIL err_sticky err=%b code=%b exp 1/01", err, err_code); end
    do_reset();
    wr("addi_min", 3'b010, 5'd0, 5'd0, 5'd0, -32'sd2048, 1'b0, 0, 8'd0, 32'h80000013, 9'd1);
    wr("addi_max", 3'b010, 5'd0, 5'd0, 5'd0, 32'd2047,   1'b0, 0, 8'd1, 32'h7FF00013, 9'd2);
    wr("beq_6",    3'b011, 5'd0, 5'd0, 5'd0, 32'd6,      1'b0, 0, 8'd2, 32'h00000363, 9'd3);
    rej("beq_5", 3'b011, 32'd5, 2'b10);
    do_reset();
    rej("beq_4097", 3'b011, 32'd4097, 2'b01);
    do_reset();
    rej("sw_m2049", 3'b001, -32'sd2049, 2'b01);
  endtask

  task automatic test_mem_full();
    logic [31:0] words [4];
    words[0] = 32'h00000093; words[1] = 32'h00100093;
    words[2] = 32'h00200093; words[3] = 32'h00300093;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_fields(3'b010, 5'd1, 5'd0, 5'd0, 32'(i), 1'b0);
      s_valid = 1'b1;
      @(negedge clock);
      s_valid = 1'b0;
      total++; if (s_we !== 1'b1 || s_addr !== 2'(i) || s_wdata !== words[i]) begin
        bad++; $display("FAIL full_wr%0d we=%b addr=%0d word=%h exp 1/%0d/%h", i, s_we, s_addr, s_wdata, i, words[i]); end
      s_ack = 1'b1;
      @(negedge clock);
      s_ack = 1'b0;
      total++; if (s_count !== 3'(i + 1)) begin
        bad++; $display("FAIL full_cnt%0d got=%0d exp=%0d", i, s_count, i + 1); end
    end
    set_fields(3'b010, 5'd1, 5'd0, 5'd0, 32'd4, 1'b0);
    s_valid = 1'b1;
    @(negedge clock);
    s_valid = 1'b0;
    total++; if (s_we !== 1'b0 || s_err !== 1'b1 || s_code !== 2'b11 || s_count !== 3'd4) begin
      bad++; $display("FAIL full_fifth we=%b err=%b code=%b cnt=%0d exp 0/1/11/4", s_we, s_err, s_code, s_count); end
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    wr("pre", 3'b010, 5'd1, 5'd0, 5'd0, 32'd1, 1'b0, 0, 8'd0, 32'h00100093, 9'd1);
    set_fields(3'b000, 5'd5, 5'd10, 5'd0, 32'd48, 1'b0);
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL mid_we got=%b exp=1", mem_we); end
    reset = 1'b1;
    @(negedge clock);
    total++; if (mem_we !== 1'b0 || count !== 9'd0 || mem_addr !== 8'd0) begin
      bad++; $display("FAIL mid_reset we=%b cnt=%0d addr=%0d exp 0/0/0", mem_we, count, mem_addr); end
    reset = 1'b0;
    #1;
    wr("post", 3'b000, 5'd5, 5'd10, 5'd0, 32'd48, 1'b0, 0, 8'd0, 32'h03052283, 9'd1);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_last();
    test_ack_stall();
    test_imm_range();
    test_mem_full();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
